mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DWIDTH, default 32, data and address width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  EX result (address, store data, controls) valid this cycle.
REQ-005 in_ready  output  1  stage accepts the EX result this cycle.
REQ-006 ctrl_mem_rd  input  1  instruction is a load.
REQ-007 ctrl_mem_we  input  1  instruction is a store.
REQ-008 mem_func  input  3  RISC-V funct3 (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB/SH/SW=000/001/010).
REQ-009 alu_out  input  DWIDTH  effective byte address from the ALU.
REQ-010 data_rs2  input  DWIDTH  store source data.
REQ-011 dmem_req  output  1  data-memory request valid.
REQ-012 dmem_gnt  input  1  memory accepts the request this cycle.
REQ-013 dmem_addr  output  DWIDTH  word-aligned address {addr[31:2],2'b00}.
REQ-014 dmem_wmask  output  4  byte write enables; 4'b0000 for loads.
REQ-015 dmem_wdata  output  DWIDTH  lane-replicated store data.
REQ-016 dmem_rvalid  input  1  read data valid.
REQ-017 dmem_rdata  input  DWIDTH  read word.
REQ-018 wb_valid  output  1  one-cycle pulse; wb_data holds the load result.
REQ-019 wb_data  output  DWIDTH  aligned, extended load result.
REQ-020 misaligned  output  1  one-cycle pulse flagging a misaligned access.

Function
REQ-021 FSM states: IDLE, REQ, RESP. in_ready SHALL be 1 exactly when state is IDLE.
REQ-022 IDLE, handshake (in_valid & in_ready) with ctrl_mem_we or ctrl_mem_rd set and the access aligned: latch address, mem_func, store data and op type, then go to REQ.
REQ-023 If ctrl_mem_we and ctrl_mem_rd are both 1, treat the access as a store.
REQ-024 A handshake with neither ctrl_mem_rd nor ctrl_mem_we set: consumed, no memory activity, state stays IDLE.
REQ-025 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. On such a handshake: no request, state stays IDLE, misaligned=1 in the next cycle only, no wb_valid.
REQ-026 REQ: dmem_req=1 with registered dmem_addr/dmem_wmask/dmem_wdata held stable until dmem_gnt. Earliest request is the cycle after acceptance.
REQ-027 REQ with dmem_gnt=1: a store goes to IDLE; a load goes to RESP.
REQ-028 dmem_rvalid is ignored in IDLE and REQ. The earliest valid response is the cycle after the grant.
REQ-029 RESP with dmem_rvalid=1: register wb_data, pulse wb_valid=1 in the next cycle, go to IDLE.
REQ-030 Store mask/data:
  - SB: mask 4'b0001<<addr[1:0], data {4{rs2[7:0]}}.
  - SH: mask 4'b0011<<{addr[1],1'b0}, data {2{rs2[15:0]}}.
  - SW: mask 4'b1111, data rs2.
REQ-031 Load extract from dmem_rdata:
  - LB/LBU: byte at addr[1:0], sign- or zero-extended.
  - LH/LHU: halfword at addr[1], sign- or zero-extended.
  - LW: full word.
REQ-032 mem_func values 011, 110 and 111 are treated as word access.
REQ-033 Outside active phases: dmem_req=0, dmem_wmask=0, wb_valid=0, misaligned=0. wb_data holds its last value.
REQ-034 Minimum latency:
  - Store accepted at cycle N: req at N+1, IDLE at N+2 if granted at N+1.
  - Load: rvalid at cycle M gives wb_valid at M+1.
  - Back-to-back accesses are accepted in the cycle state returns to IDLE.

Reset
REQ-035 rst_n low SHALL immediately force:
  - state IDLE and in_ready=1;
  - dmem_req=0, dmem_wmask=0, dmem_addr=0, dmem_wdata=0;
  - wb_valid=0, wb_data=0, misaligned=0.
REQ-036 Reset mid-transaction abandons the transaction with no wb_valid afterwards. A later rvalid is ignored in IDLE.

Verification
REQ-037 SW addr 0x100, rs2 0xDEADBEEF, gnt same cycle as req -> req 1 cycle, addr 0x100, mask 1111, wdata 0xDEADBEEF, in_ready back 2 cycles after accept.
REQ-038 SB addr 0x203, rs2 0x000000A5 -> addr 0x200, mask 1000, wdata 0xA5A5A5A5.
REQ-039 LB addr 0x301, rdata 0x0000_80_00 -> wb_data 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x302, rdata 0xBEEF1234 -> 0x0000BEEF.
REQ-040 LW addr 0x402 -> misaligned pulse next cycle, dmem_req never asserted, in_ready stays 1.
REQ-041 LW with gnt held low 3 cycles and rvalid 2 cycles after gnt:
  - req and addr stable 4 cycles;
  - in_ready=0 throughout;
  - single wb_valid pulse.
REQ-042 rst_n low while in RESP, rvalid after release -> no wb_valid, state IDLE, outputs at reset values.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: turns EX results into aligned data-memory requests
// and returns extended load data to writeback.
module mem_stage #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ctrl_mem_rd,
  input  logic              ctrl_mem_we,
  input  logic [2:0]        mem_func,
  input  logic [DWIDTH-1:0] alu_out,
  input  logic [DWIDTH-1:0] data_rs2,
  output logic              dmem_req,
  input  logic              dmem_gnt,
  output logic [DWIDTH-1:0] dmem_addr,
  output logic [3:0]        dmem_wmask,
  output logic [DWIDTH-1:0] dmem_wdata,
  input  logic              dmem_rvalid,
  input  logic [DWIDTH-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [DWIDTH-1:0] wb_data,
  output logic              misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        off_q;
  logic [2:0]        func_q;
  logic              store_q;
  logic [DWIDTH-1:0] addr_q, wdata_q;
  logic [3:0]        wmask_q;

  logic              accept, mem_op, mis, start;
  logic              is_byte, is_half;
  logic [3:0]        wmask_d;
  logic [DWIDTH-1:0] wdata_d, ld_data;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic              ld_sx;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;
  assign mem_op   = ctrl_mem_rd | ctrl_mem_we;
  assign is_byte  = (mem_func[1:0] == 2'b00);
  assign is_half  = (mem_func[1:0] == 2'b01);
  assign start    = accept & mem_op & ~mis;

  always_comb begin
    mis     = |alu_out[1:0];
    wmask_d = 4'b1111;
    wdata_d = data_rs2;
    unique case (1'b1)
      is_byte: begin
        mis     = 1'b0;
        wmask_d = 4'b0001 << alu_out[1:0];
        wdata_d = {4{data_rs2[7:0]}};
      end
      is_half: begin
        mis     = alu_out[0];
        wmask_d = 4'b0011 << {alu_out[1], 1'b0};
        wdata_d = {2{data_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select uses the byte offset captured at acceptance
  assign ld_b  = dmem_rdata[8*off_q +: 8];
  assign ld_h  = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign ld_sx = ~func_q[2];

  always_comb begin
    ld_data = dmem_rdata;
    unique case (func_q[1:0])
      2'b00:   ld_data = {{24{ld_sx & ld_b[7]}}, ld_b};
      2'b01:   ld_data = {{16{ld_sx & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (dmem_gnt) state_d = store_q ? IDLE : RESP;
      RESP:    if (dmem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      off_q      <= '0;
      func_q     <= '0;
      store_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      misaligned <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= {alu_out[DWIDTH-1:2], 2'b00};
        off_q   <= alu_out[1:0];
        func_q  <= mem_func;
        store_q <= ctrl_mem_we;
        wmask_q <= ctrl_mem_we ? wmask_d : 4'b0000;
        wdata_q <= wdata_d;
      end
      misaligned <= accept & mem_op & mis;
      wb_valid   <= (state_q == RESP) & dmem_rvalid;
      if ((state_q == RESP) && dmem_rvalid) wb_data <= ld_data;
    end
  end

  assign dmem_req   = (state_q == REQ);
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wmask = dmem_req ? wmask_q : 4'b0000;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with an arithmetic
// reference model of store lanes and load extraction.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        ctrl_mem_rd, ctrl_mem_we;
  logic [2:0]  mem_func;
  logic [31:0] alu_out, data_rs2;
  logic        dmem_req, dmem_gnt;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        misaligned;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_wb = '0;

  always #5 clk = ~clk;

  mem_stage #(.DWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_mem_rd(ctrl_mem_rd), .ctrl_mem_we(ctrl_mem_we),
    .mem_func(mem_func), .alu_out(alu_out), .data_rs2(data_rs2),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .misaligned(misaligned)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned size_of(input logic [2:0] f);
    int unsigned k;
    k = f % 4;
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] d);
    int unsigned sz, off;
    logic [31:0] v;
    sz  = size_of(f);
    off = a % 4;
    if (sz == 4) return d;
    if (sz == 1) begin
      v = (d >> (8 * off)) % 256;
      if (f < 4 && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = (d >> (16 * (off / 2))) % 65536;
      if (f < 4 && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic do_op(input bit rd, input bit we,
                       input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] rs2,
                       input int g, input int r,
                       input logic [31:0] rdata);
    int unsigned sz, off;
    logic [3:0]  em;
    logic [31:0] ed, el;
    @(negedge clk);
    check("idle_wbv", wb_valid, 0);
    check("idle_mis", misaligned, 0);
    check("idle_req", dmem_req, 0);
    check("hold_wbd", wb_data, last_wb);
    in_valid = 1; ctrl_mem_rd = rd; ctrl_mem_we = we;
    mem_func = f; alu_out = a; data_rs2 = rs2;
    check("rdy_acc", in_ready, 1);
    @(negedge clk);
    in_valid = 0; ctrl_mem_rd = 0; ctrl_mem_we = 0;
    alu_out = $urandom; data_rs2 = $urandom;
    sz  = size_of(f);
    off = a % 4;
    if (!rd && !we) begin
      check("nop_req", dmem_req, 0);
      check("nop_mis", misaligned, 0);
      check("nop_rdy", in_ready, 1);
      return;
    end
    if ((a % sz) != 0) begin
      check("mis_pulse", misaligned, 1);
      check("mis_req", dmem_req, 0);
      check("mis_rdy", in_ready, 1);
      return;
    end
    em = 4'h0;
    ed = rs2;
    if (we) begin
      if (sz == 1) begin
        em = 4'(1 << off);
        ed = (rs2 % 256) * 32'h0101_0101;
      end else if (sz == 2) begin
        em = 4'(3 << (off / 2 * 2));
        ed = (rs2 % 65536) * 32'h0001_0001;
      end else begin
        em = 4'hF;
      end
    end
    for (int i = 0; i <= g; i++) begin
      check("req", dmem_req, 1);
      check("req_addr", dmem_addr, a - off);
      check("req_mask", dmem_wmask, em);
      if (we) check("req_wdata", dmem_wdata, ed);
      check("req_rdy", in_ready, 0);
      dmem_gnt    = (i == g);
      dmem_rvalid = 1'($urandom % 2);
      dmem_rdata  = $urandom;
      @(negedge clk);
    end
    dmem_gnt = 0; dmem_rvalid = 0;
    check("post_req", dmem_req, 0);
    check("post_mask", dmem_wmask, 0);
    if (we) begin
      check("st_rdy", in_ready, 1);
      return;
    end
    for (int i = 0; i < r; i++) begin
      check("resp_rdy", in_ready, 0);
      check("resp_wbv", wb_valid, 0);
      @(negedge clk);
    end
    check("resp_rdy", in_ready, 0);
    dmem_rvalid = 1; dmem_rdata = rdata;
    @(negedge clk);
    dmem_rvalid = 0; dmem_rdata = $urandom;
    el = exp_load(f, a, rdata);
    check("wb_valid", wb_valid, 1);
    check("wb_data", wb_data, el);
    check("ld_rdy", in_ready, 1);
    last_wb = el;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; ctrl_mem_rd = 0; ctrl_mem_we = 0;
    mem_func = 0; alu_out = 0; data_rs2 = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    repeat (3) @(negedge clk);
    check("rst_rdy", in_ready, 1);
    check("rst_req", dmem_req, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wbd", wb_data, 0);
    rst_n = 1;

    do_op(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
    do_op(0, 1, 3'b000, 32'h203, 32'h0000_00A5, 0, 0, 0);
    do_op(1, 0, 3'b000, 32'h301, 0, 0, 0, 32'h0000_8000);
    do_op(1, 0, 3'b100, 32'h301, 0, 1, 1, 32'h0000_8000);
    do_op(1, 0, 3'b101, 32'h302, 0, 0, 0, 32'hBEEF_1234);
    do_op(1, 0, 3'b010, 32'h402, 0, 0, 0, 0);
    do_op(1, 0, 3'b010, 32'h404, 0, 3, 1, 32'hCAFE_F00D);
    do_op(1, 1, 3'b001, 32'h506, 32'h1234_5678, 1, 0, 0);
    do_op(0, 0, 3'b010, 32'h601, 0, 0, 0, 0);
    do_op(1, 0, 3'b111, 32'h708, 0, 0, 2, 32'h8765_4321);

    for (int n = 0; n < 300; n++) begin
      logic [2:0]  f;
      logic [31:0] a;
      bit          rd, we;
      f  = 3'($urandom % 8);
      a  = $urandom;
      if ($urandom % 4 != 0) a = a - (a % size_of(f));
      rd = 1'($urandom % 2);
      we = 1'($urandom % 2);
      do_op(rd, we, f, a, $urandom, int'($urandom % 4),
            int'($urandom % 3), $urandom);
    end

    // Reset while waiting for read data abandons the load
    @(negedge clk);
    in_valid = 1; ctrl_mem_rd = 1; mem_func = 3'b010;
    alu_out = 32'h800;
    @(negedge clk);
    in_valid = 0; ctrl_mem_rd = 0; dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    check("pre_rst_rdy", in_ready, 0);
    rst_n = 0;
    #1;
    check("arst_rdy", in_ready, 1);
    check("arst_req", dmem_req, 0);
    check("arst_mask", dmem_wmask, 0);
    check("arst_addr", dmem_addr, 0);
    check("arst_wdata", dmem_wdata, 0);
    check("arst_wbd", wb_data, 0);
    check("arst_mis", misaligned, 0);
    @(negedge clk);
    rst_n = 1; dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_rvalid = 0;
    check("late_rv_wbv", wb_valid, 0);
    check("late_rv_wbd", wb_data, 0);
    check("late_rv_rdy", in_ready, 1);
    @(negedge clk);
    check("late_rv_wbv2", wb_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
